// File: rtl/ocimem_access_arbiter.sv
// Shares the single-port OCI debug memory between JTAG debug strobes (captured
// into a one-deep pending slot, strict priority) and the CPU Avalon-MM debug slave.
module ocimem_access_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int ROM_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              mondreg_valid,
    output logic              jtag_busy,
    output logic              jtag_overrun
);
    typedef enum logic [2:0] {S_IDLE, S_JRD, S_JCAP, S_CRD, S_CCAP} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ROM_LIMIT = (ADDR_W+1)'(ROM_WORDS);

    state_t            r_state;
    logic              r_slot_vld;
    logic              r_slot_wr;
    logic [31:0]       r_slot_data;
    logic [ADDR_W-1:0] r_maddr;
    logic [31:0]       r_mondreg;
    logic              r_mondreg_vld;
    logic              r_overrun;

    logic              w_strobe;
    logic              w_jtag_busy;
    logic              w_accept;
    logic              w_drop;
    logic [ADDR_W-1:0] w_jaddr;
    logic              w_cpu_wr_ok;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_wren;
    logic [31:0]       w_ram_wdata;
    logic              w_waitreq;
    logic [31:0]       w_readdata;
    logic              w_unused;

    assign w_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_jtag_busy = r_slot_vld | (r_state == S_JRD) | (r_state == S_JCAP);
    assign w_accept    = w_strobe & ~w_jtag_busy;
    assign w_drop      = w_strobe & w_jtag_busy;
    assign w_jaddr     = jdo[16+ADDR_W:17];
    assign w_cpu_wr_ok = ({1'b0, avs_address} >= ROM_LIMIT);
    assign w_unused    = ^{jdo[37:35], jdo[2:0]};

    // Control FSM, JTAG slot capture, address pointer and MonDReg update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_slot_vld    <= 1'b0;
            r_slot_wr     <= 1'b0;
            r_slot_data   <= '0;
            r_maddr       <= '0;
            r_mondreg     <= '0;
            r_mondreg_vld <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_mondreg_vld <= 1'b0;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            // Accepting only when idle means capture never collides with the FSM's own slot/maddr updates.
            if (w_accept) begin
                if (take_action_ocimem_a) begin
                    r_maddr <= w_jaddr;
                end else begin
                    r_slot_vld  <= 1'b1;
                    r_slot_wr   <= take_action_ocimem_b;
                    r_slot_data <= jdo[34:3];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (r_slot_vld) begin
                        if (r_slot_wr) begin
                            r_slot_vld <= 1'b0;
                            r_maddr    <= r_maddr + ADDR_ONE;
                        end else begin
                            r_state <= S_JRD;
                        end
                    end else if (avs_read && !avs_write) begin
                        r_state <= S_CRD;
                    end
                end
                S_JRD: begin
                    r_maddr <= r_maddr + ADDR_ONE;
                    r_state <= S_JCAP;
                end
                S_JCAP: begin
                    r_mondreg     <= ram_rdata;
                    r_mondreg_vld <= 1'b1;
                    r_slot_vld    <= 1'b0;
                    r_state       <= S_IDLE;
                end
                S_CRD:   r_state <= S_CCAP;
                S_CCAP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory and Avalon handshake decode from the current state.
    always_comb begin
        w_ram_addr  = r_maddr;
        w_ram_wren  = 1'b0;
        w_ram_wdata = r_slot_data;
        w_waitreq   = 1'b1;
        w_readdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_slot_vld) begin
                    w_ram_wren = r_slot_wr;
                end else if (avs_write) begin
                    w_ram_addr  = avs_address;
                    w_ram_wdata = avs_writedata;
                    w_ram_wren  = w_cpu_wr_ok;
                    w_waitreq   = 1'b0;
                end else if (avs_read) begin
                    w_ram_addr = avs_address;
                end
            end
            S_JRD:   w_ram_addr = r_maddr;
            S_CRD:   w_ram_addr = avs_address;
            S_CCAP: begin
                w_ram_addr = avs_address;
                w_readdata = ram_rdata;
                w_waitreq  = 1'b0;
            end
            default: ;
        endcase
        // State is already IDLE under reset, but a held avs_write must not leak through.
        if (!reset_n) begin
            w_ram_wren = 1'b0;
            w_waitreq  = 1'b1;
        end
    end

    assign ram_addr        = w_ram_addr;
    assign ram_wren        = w_ram_wren;
    assign ram_wdata       = w_ram_wdata;
    assign avs_waitrequest = w_waitreq;
    assign avs_readdata    = w_readdata;
    assign MonDReg         = r_mondreg;
    assign mondreg_valid   = r_mondreg_vld;
    assign jtag_busy       = w_jtag_busy;
    assign jtag_overrun    = r_overrun;

endmodule

// File: tb/tb_ocimem_access_arbiter.sv
// Self-checking bench for ocimem_access_arbiter: directed vectors, multi-cycle
// corner sequences, and a randomized phase checked against a shadow memory model.
module tb_ocimem_access_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        mondreg_valid;
    logic        jtag_busy;
    logic        jtag_overrun;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem    [256];
    logic [31:0] shadow [256];

    always #5 clk = ~clk;

    ocimem_access_arbiter #(.ADDR_W(8), .ROM_WORDS(128)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .mondreg_valid           (mondreg_valid),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    function automatic logic [31:0] init_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        if (b == 8'h10) return 32'hDEADBEEF;
        return {8'hC0, b, ~b, b ^ 8'h5A};
    endfunction

    // Single-port memory, 1-cycle read latency; reloaded with a known pattern during reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            ram_rdata <= '0;
        end else begin
            if (ram_wren) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // kind: 0 = action_a, 1 = action_b, 2 = no_action_a; one-cycle pulse.
    task automatic jstrobe(input int kind, input logic [37:0] j);
        @(negedge clk);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic rand_jtag();
        logic [7:0]  ma;
        logic [31:0] d;
        int          nops;
        int          w;
        for (int s = 0; s < 12; s++) begin
            ma = 8'($urandom_range(0, 'h70));
            jstrobe(0, jdo_addr(ma));
            nops = int'($urandom_range(1, 8));
            for (int k = 0; k < nops; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    d = $urandom;
                    jstrobe(1, jdo_data(d));
                    shadow[ma] = d;
                    ma++;
                    w = 0;
                    #1;
                    while (jtag_busy && w < 40) begin @(negedge clk); #1; w++; end
                    chk1("rnd_jtag_write_done", jtag_busy, 1'b0);
                end else begin
                    jstrobe(2, '0);
                    w = 0;
                    #1;
                    while (!mondreg_valid && w < 40) begin @(negedge clk); #1; w++; end
                    chk1("rnd_jtag_read_done", mondreg_valid, 1'b1);
                    chk32("rnd_mondreg", MonDReg, shadow[ma]);
                    ma++;
                end
            end
        end
    endtask

    task automatic rand_cpu();
        logic [7:0]  a;
        logic [31:0] d;
        logic        is_wr;
        int          w;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            is_wr = ($urandom_range(0, 1) == 1);
            a = is_wr ? 8'($urandom_range(0, 255)) : 8'($urandom_range(128, 255));
            d = $urandom;
            @(negedge clk);
            avs_address   = a;
            avs_writedata = d;
            avs_write     = is_wr;
            avs_read      = !is_wr;
            w = 0;
            #1;
            while (avs_waitrequest && w < 50) begin @(negedge clk); #1; w++; end
            chk1("rnd_cpu_done", avs_waitrequest, 1'b0);
            if (is_wr) begin
                if (a >= 8'h80) shadow[a] = d;
            end else begin
                chk32("rnd_cpu_read", avs_readdata, shadow[a]);
            end
            @(negedge clk);
            avs_read  = 1'b0;
            avs_write = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        rd;
        logic        wren;
    } wvec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        wvec_t       vec [6];
        int          pulses;
        int          bad;
        logic [31:0] exp_word;

        vec[0] = '{addr: 8'h05, data: 32'h0000_0055, rd: 1'b0, wren: 1'b0};
        vec[1] = '{addr: 8'h85, data: 32'h0000_0055, rd: 1'b0, wren: 1'b1};
        vec[2] = '{addr: 8'h7F, data: 32'h1111_2222, rd: 1'b0, wren: 1'b0};
        vec[3] = '{addr: 8'h80, data: 32'h3333_4444, rd: 1'b0, wren: 1'b1};
        vec[4] = '{addr: 8'hFF, data: 32'hCAFE_F00D, rd: 1'b1, wren: 1'b1};
        vec[5] = '{addr: 8'h00, data: 32'h0000_0BAD, rd: 1'b1, wren: 1'b0};

        // Reset with a CPU write held: nothing may leak out.
        avs_write   = 1'b1;
        avs_address = 8'h90;
        repeat (3) @(negedge clk);
        #1;
        chk1 ("rst_wren",      ram_wren, 1'b0);
        chk1 ("rst_waitreq",   avs_waitrequest, 1'b1);
        chk32("rst_readdata",  avs_readdata, 32'h0);
        chk32("rst_mondreg",   MonDReg, 32'h0);
        chk1 ("rst_valid",     mondreg_valid, 1'b0);
        chk1 ("rst_overrun",   jtag_overrun, 1'b0);
        chk1 ("rst_busy",      jtag_busy, 1'b0);
        @(negedge clk);
        reset_n     = 1'b1;
        avs_write   = 1'b0;
        avs_address = '0;

        // Single-cycle CPU writes from IDLE, ROM writes dropped.
        for (int i = 0; i < 6; i++) begin
            nxt();
            avs_address   = vec[i].addr;
            avs_writedata = vec[i].data;
            avs_write     = 1'b1;
            avs_read      = vec[i].rd;
            #1;
            chk1 ("tbl_wren",    ram_wren, vec[i].wren);
            chk1 ("tbl_waitreq", avs_waitrequest, 1'b0);
            chk32("tbl_addr",    32'(ram_addr), 32'(vec[i].addr));
            chk32("tbl_wdata",   ram_wdata, vec[i].data);
            nxt();
            avs_write = 1'b0;
            avs_read  = 1'b0;
            #1;
            chk1("tbl_waitreq_after", avs_waitrequest, 1'b1);
            chk1("tbl_wren_after",    ram_wren, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            exp_word = vec[i].wren ? vec[i].data : init_val(int'(vec[i].addr));
            chk32("tbl_mem", mem[vec[i].addr], exp_word);
        end

        // JTAG read: action_a at T, no_action_a at T+2, MonDReg at T+6.
        nxt(); take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h10); #1;
        chk1("seta_not_busy", jtag_busy, 1'b0);
        nxt();
        nxt(); take_no_action_ocimem_a = 1'b1; #1;
        chk1("rd_strobe_cycle_busy", jtag_busy, 1'b0);
        nxt(); #1; chk1("rd_pending_busy", jtag_busy, 1'b1);
        nxt(); #1; chk32("jrd_addr", 32'(ram_addr), 32'h10);
        chk1("jrd_wren", ram_wren, 1'b0);
        nxt(); #1; chk1("valid_early", mondreg_valid, 1'b0);
        nxt(); #1; chk1("valid_t6", mondreg_valid, 1'b1);
        chk32("mondreg_t6", MonDReg, 32'hDEADBEEF);
        nxt(); #1; chk1("valid_one_cycle", mondreg_valid, 1'b0);
        chk1("busy_cleared", jtag_busy, 1'b0);

        // CPU read held while a JTAG read is pending; maddr continues at 0x11.
        nxt(); take_no_action_ocimem_a = 1'b1;
        nxt(); avs_read = 1'b1; avs_address = 8'h85; #1;
        chk1("hold_wait_idle", avs_waitrequest, 1'b1);
        nxt(); #1; chk1("hold_wait_jrd", avs_waitrequest, 1'b1);
        chk32("hold_jrd_addr", 32'(ram_addr), 32'h11);
        nxt(); #1; chk1("hold_wait_jcap", avs_waitrequest, 1'b1);
        nxt(); #1; chk1("hold_wait_idle2", avs_waitrequest, 1'b1);
        chk1("hold_valid", mondreg_valid, 1'b1);
        chk32("hold_mondreg", MonDReg, init_val(8'h11));
        nxt(); #1; chk1("hold_wait_crd", avs_waitrequest, 1'b1);
        chk32("hold_crd_addr", 32'(ram_addr), 32'h85);
        nxt(); #1; chk1("hold_wait_ccap", avs_waitrequest, 1'b0);
        chk32("hold_readdata", avs_readdata, 32'h55);
        nxt(); avs_read = 1'b0; #1;
        chk1("hold_wait_done", avs_waitrequest, 1'b1);

        // JTAG writes across the address wrap.
        nxt(); take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'hFF);
        nxt();
        nxt();
        nxt(); take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h12345678);
        nxt(); #1;
        chk1 ("wr1_wren", ram_wren, 1'b1);
        chk32("wr1_addr", 32'(ram_addr), 32'hFF);
        chk32("wr1_data", ram_wdata, 32'h12345678);
        chk1 ("wr1_waitreq", avs_waitrequest, 1'b1);
        nxt();
        nxt(); take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h9ABCDEF0);
        nxt(); #1;
        chk1 ("wr2_wren", ram_wren, 1'b1);
        chk32("wr2_addr", 32'(ram_addr), 32'h00);
        chk32("wr2_data", ram_wdata, 32'h9ABCDEF0);
        nxt(); #1;
        chk1 ("wr_idle_wren", ram_wren, 1'b0);
        chk32("mem_ff", mem[8'hFF], 32'h12345678);
        chk32("mem_00", mem[8'h00], 32'h9ABCDEF0);

        // Back-to-back reads: second dropped, sticky overrun, single pulse.
        nxt(); take_no_action_ocimem_a = 1'b1;
        nxt(); take_no_action_ocimem_a = 1'b1; #1;
        chk1("ovr_not_yet", jtag_overrun, 1'b0);
        nxt(); #1; chk1("ovr_set", jtag_overrun, 1'b1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            nxt(); #1;
            if (mondreg_valid) pulses++;
        end
        chk32("ovr_pulses", 32'(pulses), 32'd1);
        chk32("ovr_mondreg", MonDReg, init_val(8'h01));
        chk1 ("ovr_sticky", jtag_overrun, 1'b1);

        // Reset asserted in JRD aborts the read.
        nxt(); take_no_action_ocimem_a = 1'b1;
        nxt();
        nxt(); #1; chk1("abort_in_service", jtag_busy, 1'b1);
        reset_n       = 1'b0;
        avs_write     = 1'b1;
        avs_address   = 8'h90;
        avs_writedata = 32'hFFFF_FFFF;
        #1;
        chk1 ("abort_wren",     ram_wren, 1'b0);
        chk1 ("abort_waitreq",  avs_waitrequest, 1'b1);
        chk32("abort_readdata", avs_readdata, 32'h0);
        chk32("abort_mondreg",  MonDReg, 32'h0);
        chk1 ("abort_valid",    mondreg_valid, 1'b0);
        chk1 ("abort_overrun",  jtag_overrun, 1'b0);
        chk1 ("abort_busy",     jtag_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        avs_write = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            nxt(); #1;
            if (mondreg_valid) pulses++;
        end
        chk32("abort_no_pulse", 32'(pulses), 32'd0);
        chk1 ("abort_idle_busy", jtag_busy, 1'b0);

        // Randomized concurrent JTAG and CPU traffic against a shadow memory.
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        fork
            rand_jtag();
            rand_cpu();
        join
        nxt(); #1;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== shadow[i]) begin
                if (bad < 4) $display("note: mem[%0h]=%h shadow=%h", i, mem[i], shadow[i]);
                bad++;
            end
        end
        chk32("rnd_mem_words_wrong", 32'(bad), 32'd0);
        chk1 ("rnd_no_overrun", jtag_overrun, 1'b0);
        chk1 ("rnd_end_busy", jtag_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
